// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, gain ratio, pi terms
// and the vectoring FSM state encoding.
package cordic_pkg;

  localparam int FRAC_BITS = 20;
  localparam int ATAN_N    = 18;

  localparam logic signed [23:0] CORDIC_RATIO = 24'h09B74E;
  localparam logic signed [23:0] PI           = 24'h3243F7;
  localparam logic signed [23:0] PI_HALF      = 24'h1921FB;

  // atan(2^-i) in Q4.20, rounded
  localparam logic signed [23:0] ATAN [ATAN_N] = '{
    24'h0C90FE, 24'h076B1B, 24'h03EB6E, 24'h01FD5D,
    24'h00FFAB, 24'h007FF5, 24'h003FFF, 24'h002000,
    24'h001000, 24'h000800, 24'h000400, 24'h000200,
    24'h000100, 24'h000080, 24'h000040, 24'h000020,
    24'h000010, 24'h000008
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ITER  = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/cordic_vector_iter_if.sv
// Handshake bundle for the iterative CORDIC vectoring block:
// vector in on one valid/ready pair, magnitude/angle out on another.
interface cordic_vector_iter_if #(
  parameter int ARG_WIDTH = 24
);

  logic                        in_valid;
  logic                        in_ready;
  logic signed [ARG_WIDTH-1:0] x_in;
  logic signed [ARG_WIDTH-1:0] y_in;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ARG_WIDTH-1:0] magnitude;
  logic signed [ARG_WIDTH-1:0] angle;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, magnitude, angle
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, magnitude, angle
  );

endinterface

// File: rtl/cordic_vector_iter.sv
// Iterative CORDIC in vectoring mode: one micro-rotation per cycle,
// producing gain-compensated magnitude and atan2 angle in Q4.20.
module cordic_vector_iter #(
  parameter int          ARG_WIDTH    = 24,
  parameter int          ITER_WIDTH   = 5,
  parameter int          ITER_CNT     = 18,
  parameter logic [23:0] CORDIC_RATIO = 24'h09B74E
) (
  input logic           clk,
  input logic           rst,
  cordic_vector_iter_if.slave bus
);

  import cordic_pkg::*;

  localparam int W2  = 2 * ARG_WIDTH;
  localparam int MSB = ARG_WIDTH - 1;

  state_e                      state;
  logic [ITER_WIDTH-1:0]       cnt;
  logic signed [ARG_WIDTH-1:0] x;
  logic signed [ARG_WIDTH-1:0] y;
  logic signed [ARG_WIDTH-1:0] z;
  logic signed [ARG_WIDTH-1:0] xs;
  logic signed [ARG_WIDTH-1:0] ys;
  logic signed [ARG_WIDTH-1:0] mag;
  logic signed [ARG_WIDTH-1:0] ang;
  logic signed [ARG_WIDTH-1:0] scaled;
  logic                        zero;

  assign xs = x >>> cnt;
  assign ys = y >>> cnt;

  // keep bits [FRAC+W-1:FRAC] of the full-width signed product
  assign scaled = ARG_WIDTH'(
    (W2'(x) * W2'($signed(CORDIC_RATIO))) >>> FRAC_BITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      zero  <= 1'b0;
      mag   <= '0;
      ang   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x     <= bus.x_in;
            y     <= bus.y_in;
            state <= S_PRE;
          end
        end
        S_PRE: begin
          cnt   <= '0;
          zero  <= (x == '0) && (y == '0);
          state <= S_ITER;
          // fold left half-plane into the right by +-90 degrees
          if (!x[MSB]) begin
            z <= '0;
          end else if (!y[MSB]) begin
            x <= y;
            y <= -x;
            z <= PI_HALF;
          end else begin
            x <= -y;
            y <= x;
            z <= -PI_HALF;
          end
        end
        S_ITER: begin
          if (!y[MSB]) begin
            x <= x + ys;
            y <= y - xs;
            z <= z + ATAN[cnt];
          end else begin
            x <= x - ys;
            y <= y + xs;
            z <= z - ATAN[cnt];
          end
          cnt <= cnt + 1'b1;
          if (cnt == ITER_WIDTH'(ITER_CNT - 1))
            state <= S_SCALE;
        end
        S_SCALE: begin
          mag   <= zero ? '0 : scaled;
          ang   <= zero ? '0 : z;
          state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.magnitude = mag;
  assign bus.angle     = ang;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Bench for cordic_vector_iter: directed vectors plus random vectors
// compared against ideal sqrt/atan2 within the accuracy window.
module tb_cordic_vector_iter;

  localparam real    SC     = 1048576.0;
  localparam longint TWO_PI = 64'sd6588397;
  localparam longint ONE    = 64'sd1048576;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cordic_vector_iter_if #(.ARG_WIDTH(24)) bus ();

  cordic_vector_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs,
                         input longint exp, input longint tol,
                         input bit wrap);
    longint d;
    total++;
    d = obs - exp;
    if (wrap && d > TWO_PI / 2) d = d - TWO_PI;
    if (wrap && d < -TWO_PI / 2) d = d + TWO_PI;
    assert (d <= tol && d >= -tol) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d",
             tag, obs, exp, tol);
    end
  endtask

  function automatic longint ideal_mag(input longint x, input longint y);
    return longint'($sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
  endfunction

  function automatic longint ideal_ang(input longint x, input longint y);
    return longint'($atan2(real'(y), real'(x)) * SC);
  endfunction

  function automatic longint mag_now();
    return longint'($signed(bus.magnitude));
  endfunction

  function automatic longint ang_now();
    return longint'($signed(bus.angle));
  endfunction

  task automatic send(input longint x, input longint y);
    bus.x_in     = 24'(x);
    bus.y_in     = 24'(y);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input longint x,
                         input longint y, input longint em,
                         input longint ea, input longint tm,
                         input longint ta);
    int lat;
    send(x, y);
    wait_out(lat);
    chk({tag, "_latency"}, lat, 20);
    chk_tol({tag, "_mag"}, mag_now(), em, tm, 1'b0);
    chk_tol({tag, "_ang"}, ang_now(), ea, ta, 1'b1);
    release_out();
    chk({tag, "_ready_after"}, bus.in_ready, 1);
  endtask

  initial begin
    int     lat;
    bit     ok;
    longint hm;
    longint ha;
    longint rx;
    longint ry;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mag", mag_now(), 0);
    chk("rst_ang", ang_now(), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_vec("x1", ONE, 0, ONE, 0, 32, 16);
    run_vec("y1", 0, ONE, ONE, 64'sh1921FB, 32, 16);
    run_vec("xm1", -ONE, 0, ONE, 64'sh3243F7, 32, 16);
    run_vec("x1y1", ONE, ONE, 64'sh16A09E, 64'sh0C90FE, 32, 16);
    run_vec("xm1ym1", -ONE, -ONE, 64'sh16A09E, -64'sd2470649, 32, 16);
    run_vec("zero", 0, 0, 0, 0, 0, 0);

    send(ONE, ONE);
    wait_out(lat);
    chk("hold_latency", lat, 20);
    hm = mag_now();
    ha = ang_now();
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.x_in     = 24'(-ONE / 2);
        bus.y_in     = 24'(ONE);
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (mag_now() != hm || ang_now() != ha) ok = 1'b0;
      if (bus.in_ready || !bus.out_valid) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    release_out();
    chk("hold_ready_after", bus.in_ready, 1);
    rx = -ONE;
    ry = ONE / 2;
    run_vec("b2b", rx, ry, ideal_mag(rx, ry), ideal_ang(rx, ry), 32, 16);

    hm = mag_now();
    send(ONE * 3 / 4, -ONE * 5 / 4);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_mag_stable", mag_now(), hm);
    chk("busy_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_mag", mag_now(), 0);
    chk("midrst_ang", ang_now(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ok = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) ok = 1'b0;
    end
    chk("midrst_no_result", ok, 1);
    rx = ONE / 3;
    ry = -ONE * 7 / 5;
    run_vec("post_rst", rx, ry, ideal_mag(rx, ry), ideal_ang(rx, ry),
            32, 16);

    for (int n = 0; n < 12; n++) begin
      do begin
        rx = longint'($urandom_range(0, 3800000)) - 1900000;
        ry = longint'($urandom_range(0, 3800000)) - 1900000;
      end while (ideal_mag(rx, ry) < 786432);
      run_vec($sformatf("rnd%0d", n), rx, ry, ideal_mag(rx, ry),
              ideal_ang(rx, ry), 32, 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
